// File: rtl/axis_frame_arbiter_if.sv
// AXI4-Stream video link: pixel data with tuser marking start of frame and tlast
// marking end of line.
interface axis_frame_arbiter_if #(
  parameter int unsigned C_PIXEL_WIDTH = 8
) ();
  logic                     tvalid;
  logic [C_PIXEL_WIDTH-1:0] tdata;
  logic                     tuser;
  logic                     tlast;
  logic                     tready;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis_frame_arbiter.sv
// Two-source whole-frame round-robin arbiter feeding one registered AXI4-Stream output.
// Define AXIS_FRAME_ARB_DRAIN_EN to discard stale non-SOF beats offered while idle.
module axis_frame_arbiter #(
  parameter int unsigned C_PIXEL_WIDTH = 8,
  parameter int unsigned C_IMG_HEIGHT  = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  axis_frame_arbiter_if.slave  s0_axis,
  axis_frame_arbiter_if.slave  s1_axis,
  axis_frame_arbiter_if.master m_axis,
  output logic [1:0]           grant,
  output logic                 busy
);
  localparam int unsigned LineW = $clog2(C_IMG_HEIGHT) + 1;
  localparam logic [LineW-1:0] LastLine = LineW'(C_IMG_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [LineW-1:0]   line_cnt_q, line_cnt_d;

  logic                     out_valid_q;
  logic [C_PIXEL_WIDTH-1:0] out_data_q;
  logic                     out_user_q;
  logic                     out_last_q;

  logic                     req0, req1, can_load;
  logic                     in_valid, in_user, in_last, in_acc, frame_done;
  logic [C_PIXEL_WIDTH-1:0] in_data;
  logic [LineW-1:0]         line_base;

  assign req0     = s0_axis.tvalid & s0_axis.tuser;
  assign req1     = s1_axis.tvalid & s1_axis.tuser;
  assign can_load = ~out_valid_q | m_axis.tready;

  always_comb begin
    in_valid = 1'b0;
    in_data  = '0;
    in_user  = 1'b0;
    in_last  = 1'b0;
    case (state_q)
      StGrant0: begin
        in_valid = s0_axis.tvalid;
        in_data  = s0_axis.tdata;
        in_user  = s0_axis.tuser;
        in_last  = s0_axis.tlast;
      end
      StGrant1: begin
        in_valid = s1_axis.tvalid;
        in_data  = s1_axis.tdata;
        in_user  = s1_axis.tuser;
        in_last  = s1_axis.tlast;
      end
      default: ;
    endcase
  end

  assign in_acc     = in_valid & can_load;
  // Any SOF beat, first or early, starts the line count from zero.
  assign line_base  = in_user ? '0 : line_cnt_q;
  assign frame_done = in_acc & in_last & (line_base == LastLine);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      line_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      line_cnt_q   <= line_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    line_cnt_d   = line_cnt_q;
    case (state_q)
      StIdle: begin
        line_cnt_d = '0;
        if (req0 & (~req1 | last_grant_q)) begin
          state_d = StGrant0;
        end else if (req1) begin
          state_d = StGrant1;
        end
      end
      StGrant0, StGrant1: begin
        if (in_acc) begin
          line_cnt_d = line_base + LineW'(in_last);
          if (frame_done) begin
            state_d      = StIdle;
            last_grant_d = (state_q == StGrant1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s0_axis.tready = ~reset & (state_q == StGrant0) & can_load;
    s1_axis.tready = ~reset & (state_q == StGrant1) & can_load;
`ifdef AXIS_FRAME_ARB_DRAIN_EN
    // tuser=1 while idle is a request, so only non-SOF beats are swallowed.
    s0_axis.tready = s0_axis.tready | (~reset & (state_q == StIdle) & ~s0_axis.tuser);
    s1_axis.tready = s1_axis.tready | (~reset & (state_q == StIdle) & ~s1_axis.tuser);
`endif
    grant = {state_q == StGrant1, state_q == StGrant0};
    busy  = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (can_load) begin
      out_valid_q <= in_acc;
      if (in_acc) begin
        out_data_q <= in_data;
        out_user_q <= in_user;
        out_last_q <= in_last;
      end
    end
  end

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tuser  = out_user_q;
  assign m_axis.tlast  = out_last_q;
endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Scoreboard bench for axis_frame_arbiter: input monitor predicts output beats per frame,
// output monitor pops and compares.
module tb_axis_frame_arbiter;
  localparam int unsigned PW   = 8;
  localparam int unsigned H    = 2;
  localparam int unsigned LPIX = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant;
  logic       busy;

  always #5 clk = ~clk;

  axis_frame_arbiter_if #(.C_PIXEL_WIDTH(PW)) s0_axis ();
  axis_frame_arbiter_if #(.C_PIXEL_WIDTH(PW)) s1_axis ();
  axis_frame_arbiter_if #(.C_PIXEL_WIDTH(PW)) m_axis ();

  axis_frame_arbiter #(.C_PIXEL_WIDTH(PW), .C_IMG_HEIGHT(H)) dut (
    .clk     (clk),
    .reset   (reset),
    .s0_axis (s0_axis),
    .s1_axis (s1_axis),
    .m_axis  (m_axis),
    .grant   (grant),
    .busy    (busy)
  );

  typedef struct packed {
    logic [PW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    owner = -1;
  int    lines = 0;
  int    drained = 0;
  int    out_count = 0;
  int    starts[$];
  int    start_cyc[$];
  int    end_cyc[$];
  int    sof_out_cyc[$];
  int    rdy_mode = 0;
  int    rdy_cnt = 0;
  logic  held_valid = 1'b0;
  beat_t held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
  initial forever begin
    case (rdy_mode)
      1: m_axis.tready = (rdy_cnt % 4 == 0) || (rdy_cnt % 4 == 3);
      2: m_axis.tready = 1'($urandom_range(0, 1));
      default: m_axis.tready = 1'b1;
    endcase
    rdy_cnt++;
    @(posedge clk);
    #1;
  end

  // Frame-level reference: a SOF accepted while no frame is open opens a frame for that
  // source; H completed lines close it; every beat of an open frame must reach the output.
  task automatic mon_src(input int n, input logic v, input logic r, input logic [PW-1:0] d,
                         input logic u, input logic l);
    if (owner != -1 && owner != n) check($sformatf("tready_excl_s%0d", n), 32'(r), 0);
    if (v && r) begin
      if (owner == -1 && !u) begin
        drained++;
      end else begin
        if (owner == -1) begin
          owner = n;
          lines = 0;
          starts.push_back(n);
          start_cyc.push_back(cyc);
        end
        check("grant_owner", 32'(grant), 32'(1 << n));
        check("busy_in_frame", 32'(busy), 1);
        exp_q.push_back('{d: d, u: u, l: l});
        if (u) lines = 0;
        if (l) lines++;
        if (lines == int'(H)) begin
          owner = -1;
          end_cyc.push_back(cyc);
        end
      end
    end
  endtask

  initial forever begin
    beat_t e;
    @(negedge clk);
    if (reset) begin
      owner = -1;
      lines = 0;
      held_valid = 1'b0;
    end else begin
      mon_src(0, s0_axis.tvalid, s0_axis.tready, s0_axis.tdata, s0_axis.tuser, s0_axis.tlast);
      mon_src(1, s1_axis.tvalid, s1_axis.tready, s1_axis.tdata, s1_axis.tuser, s1_axis.tlast);
      if (held_valid)
        check("hold_stable", 32'({m_axis.tvalid, m_axis.tdata, m_axis.tuser, m_axis.tlast}),
              32'({1'b1, held}));
      if (m_axis.tvalid && m_axis.tready) begin
        held_valid = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected: got beat %0h, required no beat", m_axis.tdata);
        end else begin
          e = exp_q.pop_front();
          if ({m_axis.tdata, m_axis.tuser, m_axis.tlast} !== e) begin
            failures++;
            $display("FAIL out_beat: got %0h/%0b/%0b, required %0h/%0b/%0b",
                     m_axis.tdata, m_axis.tuser, m_axis.tlast, e.d, e.u, e.l);
          end
        end
        out_count++;
        if (m_axis.tuser) sof_out_cyc.push_back(cyc);
      end else if (m_axis.tvalid) begin
        held_valid = 1'b1;
        held = '{d: m_axis.tdata, u: m_axis.tuser, l: m_axis.tlast};
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  task automatic drive(input int src, input logic v, input logic [PW-1:0] d, input logic u,
                       input logic l);
    if (src == 0) begin
      s0_axis.tvalid = v;
      s0_axis.tdata  = d;
      s0_axis.tuser  = u;
      s0_axis.tlast  = l;
    end else begin
      s1_axis.tvalid = v;
      s1_axis.tdata  = d;
      s1_axis.tuser  = u;
      s1_axis.tlast  = l;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int src, input logic [PW-1:0] d, input logic u, input logic l);
    logic acc;
    int   t;
    acc = 1'b0;
    t = 0;
    drive(src, 1'b1, d, u, l);
    while (!acc && t < 300) begin
      @(negedge clk);
      acc = (src == 0) ? s0_axis.tready : s1_axis.tready;
      @(posedge clk);
      #1;
      t++;
    end
    drive(src, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL accept_timeout_s%0d: beat %0h not accepted, required within 300 cycles",
               src, d);
    end
  endtask

  task automatic send_frame(input int src, input int base, input bit early, input int gap_max);
    int nlines;
    nlines = early ? int'(H) + 1 : int'(H);
    for (int ln = 0; ln < nlines; ln++) begin
      for (int px = 0; px < int'(LPIX); px++) begin
        if (gap_max > 0) idle_cycles(int'($urandom_range(0, gap_max)));
        send_beat(src, PW'(base + ln * int'(LPIX) + px),
                  (px == 0) && (ln == 0 || (early && ln == 1)), px == int'(LPIX) - 1);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      idle_cycles(1);
      t++;
    end
    idle_cycles(2);
    check(name, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int t0, b, oc;
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", 32'(m_axis.tvalid), 0);
    check("rst_m_tdata", 32'(m_axis.tdata), 0);
    check("rst_m_tuser", 32'(m_axis.tuser), 0);
    check("rst_m_tlast", 32'(m_axis.tlast), 0);
    check("rst_s0_tready", 32'(s0_axis.tready), 0);
    check("rst_s1_tready", 32'(s1_axis.tready), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single s0 frame 0x00..0x07, latency and release of grant.
    t0 = cyc;
    send_frame(0, 0, 1'b0, 0);
    @(negedge clk);
    check("t1_grant_released", 32'(grant), 0);
    check("t1_busy_released", 32'(busy), 0);
    idle_cycles(3);
    check("t1_out_count", 32'(out_count), 8);
    check("t1_sof_accept_lat", 32'(start_cyc[0] - t0), 1);
    check("t1_sof_out_lat", 32'(sof_out_cyc[0] - t0), 2);

    // Simultaneous SOF after reset: s0, s1, s0, s1 with one idle cycle between frames.
    do_reset();
    b = starts.size();
    fork
      begin
        send_frame(0, 'h10, 1'b0, 0);
        send_frame(0, 'h30, 1'b0, 0);
      end
      begin
        send_frame(1, 'h20, 1'b0, 0);
        send_frame(1, 'h40, 1'b0, 0);
      end
    join
    wait_drain("t2_drain");
    check("t2_order0", 32'(starts[b]), 0);
    check("t2_order1", 32'(starts[b + 1]), 1);
    check("t2_order2", 32'(starts[b + 2]), 0);
    check("t2_order3", 32'(starts[b + 3]), 1);
    for (int i = 1; i < 4; i++)
      check($sformatf("t2_gap%0d", i), 32'(start_cyc[b + i] - end_cyc[b + i - 1]), 2);

    // s0 SOF arrives while s1 is mid-frame.
    b = starts.size();
    fork
      send_frame(1, 'h50, 1'b0, 2);
      begin
        idle_cycles(4);
        send_frame(0, 'h60, 1'b0, 0);
      end
    join
    wait_drain("t3_drain");
    check("t3_first_s1", 32'(starts[b]), 1);
    check("t3_then_s0", 32'(starts[b + 1]), 0);

    // Downstream backpressure 1,0,0,1.
    rdy_mode = 1;
    oc = out_count;
    send_frame(0, 'h70, 1'b0, 0);
    wait_drain("t4_drain");
    rdy_mode = 0;
    check("t4_count", 32'(out_count - oc), 8);

    // Early SOF at line 1 restarts the count: three tlast beats in one grant.
    b = starts.size();
    oc = out_count;
    send_frame(0, 'h80, 1'b1, 1);
    @(negedge clk);
    check("t5_grant_released", 32'(grant), 0);
    idle_cycles(1);
    wait_drain("t5_drain");
    check("t5_one_frame", 32'(starts.size() - b), 1);
    check("t5_count", 32'(out_count - oc), 12);

    // Stale non-SOF beats while idle.
    oc = out_count;
`ifdef AXIS_FRAME_ARB_DRAIN_EN
    for (int i = 0; i < 3; i++) send_beat(0, PW'('hA0 + i), 1'b0, i == 2);
    check("t6_drained", 32'(drained), 3);
`else
    drive(0, 1'b1, 8'hA0, 1'b0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("t6_s0_tready_idle", 32'(s0_axis.tready), 0);
      check("t6_m_idle", 32'(m_axis.tvalid), 0);
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, '0, 1'b0, 1'b0);
`endif
    idle_cycles(2);
    check("t6_nothing_out", 32'(out_count - oc), 0);
    send_frame(0, 'hB0, 1'b0, 0);
    wait_drain("t6_drain");
    check("t6_frame_out", 32'(out_count - oc), 8);

    // Random traffic on both sources with random backpressure.
    rdy_mode = 2;
    oc = out_count;
    fork
      for (int f = 0; f < 4; f++) begin
        idle_cycles(int'($urandom_range(0, 3)));
        send_frame(0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 3);
      end
      for (int f = 0; f < 4; f++) begin
        idle_cycles(int'($urandom_range(0, 3)));
        send_frame(1, int'($urandom_range(0, 255)), 1'b0, 3);
      end
    join
    wait_drain("t7_drain");
    rdy_mode = 0;
    check("t7_min_count", 32'(out_count - oc >= 64), 1);
    check("final_busy", 32'(busy), 0);
`ifdef AXIS_FRAME_ARB_DRAIN_EN
    check("final_drained", 32'(drained), 3);
`else
    check("final_drained", 32'(drained), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
